// File: rtl/mips_result_scoreboard.sv
// mips_result_scoreboard: in-order writeback scoreboard; decodes issued ALU ops, queues expected results, checks core writebacks
// Ports: clk, rst_n (async active-low); issue_valid/inst/rs_value/rt_value issue side;
//   wb_valid/wb_rd/wb_value writeback side; clr sync flush; op_done/op_err 1-cycle result pulses;
//   fault sticky protocol error; pass_cnt/fail_cnt saturating counters; q_full/q_empty occupancy.
// Optional MIPS_SB_CAPTURE_EN adds cap_valid/cap_exp/cap_act/cap_rd holding the first failure.
module mips_result_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] rs_value,
  input  logic [DATA_W-1:0] rt_value,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              clr,
  output logic              op_done,
  output logic              op_err,
  output logic              fault,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
`ifdef MIPS_SB_CAPTURE_EN
  output logic              cap_valid,
  output logic [DATA_W-1:0] cap_exp,
  output logic [DATA_W-1:0] cap_act,
  output logic [4:0]        cap_rd,
`endif
  output logic              q_full,
  output logic              q_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;
  state_t state, state_n;
  logic [4:0]        q_dest [DEPTH];
  logic [DATA_W-1:0] q_exp  [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_n;
  logic [TW-1:0]     age;
  logic [5:0]        opc, fn;
  logic [4:0]        dest;
  logic [DATA_W-1:0] imm, r_res, res;
  logic r_ok, tracked, active, push, pop_wb, timeout, deq, match, overflow, underflow, do_push, pass_ev, fail_ev;
  logic unused_fields;
  assign unused_fields = ^{inst[25:21], inst[10:6]};
  assign opc   = inst[31:26];
  assign fn    = inst[5:0];
  assign imm   = {{(DATA_W-16){inst[15]}}, inst[15:0]};
  assign r_ok  = opc == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  assign dest  = opc == 6'h00 ? inst[15:11] : inst[20:16];
  assign r_res = fn == 6'h20 ? rs_value + rt_value :
                 fn == 6'h22 ? rs_value - rt_value :
                 fn == 6'h24 ? rs_value & rt_value :
                 fn == 6'h25 ? rs_value | rt_value :
                 fn == 6'h27 ? ~(rs_value | rt_value) :
                 fn == 6'h26 ? rs_value ^ rt_value :
                 {{(DATA_W-1){1'b0}}, $signed(rs_value) < $signed(rt_value)};
  assign res       = r_ok ? r_res : rs_value + imm;
  assign tracked   = (r_ok || opc == 6'h08) && dest != 5'd0;
  assign active    = state != FAULT && !clr;
  assign q_empty   = count == '0;
  assign q_full    = count == FULL;
  assign fault     = state == FAULT;
  assign push      = issue_valid && tracked && active;
  assign pop_wb    = wb_valid && active && !q_empty;
  // A timed-out head is dropped exactly like a pop, so it also frees a slot for a same-cycle push.
  assign timeout   = active && !q_empty && !wb_valid && age == TMAX;
  assign deq       = pop_wb || timeout;
  assign match     = wb_rd == q_dest[rd_ptr] && wb_value == q_exp[rd_ptr];
  assign overflow  = push && q_full && !deq;
  assign underflow = wb_valid && active && q_empty;
  assign do_push   = push && !overflow;
  assign pass_ev   = pop_wb && match;
  assign fail_ev   = (pop_wb && !match) || timeout;
  assign count_n   = count + CW'(do_push) - CW'(deq);
  always_comb begin
    state_n = clr ? IDLE :
              state == FAULT ? FAULT :
              (overflow || underflow) ? FAULT :
              count_n != '0 ? TRACK : IDLE;
  end
  always_ff @(posedge clk) begin
    if (do_push) begin
      q_dest[wr_ptr] <= dest;
      q_exp[wr_ptr]  <= res;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      age      <= '0;
      op_done  <= 1'b0;
      op_err   <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      state   <= state_n;
      op_done <= pass_ev;
      op_err  <= fail_ev;
      if (clr) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        age      <= '0;
        pass_cnt <= '0;
        fail_cnt <= '0;
      end else if (active) begin
        rd_ptr <= rd_ptr + AW'(deq);
        wr_ptr <= wr_ptr + AW'(do_push);
        count  <= count_n;
        age    <= (deq || count_n == '0) ? '0 : q_empty ? age : age + 1'b1;
        if (pass_ev && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        if (fail_ev && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end
`ifdef MIPS_SB_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_exp   <= '0;
      cap_act   <= '0;
      cap_rd    <= '0;
    end else if (clr) begin
      cap_valid <= 1'b0;
    end else if (fail_ev && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_exp   <= q_exp[rd_ptr];
      cap_act   <= timeout ? '0 : wb_value;
      cap_rd    <= timeout ? q_dest[rd_ptr] : wb_rd;
    end
  end
`endif
endmodule

// File: tb/tb_mips_result_scoreboard.sv
// tb_mips_result_scoreboard: table vectors, corner sequences and a queue-model random run for the scoreboard
module tb_mips_result_scoreboard;
  localparam int DEPTH = 8;
  localparam int TIMEOUT = 16;
  logic clk, rst_n, issue_valid, wb_valid, clr;
  logic [31:0] inst, rs_value, rt_value, wb_value;
  logic [4:0] wb_rd;
  logic op_done, op_err, fault, q_full, q_empty;
  logic [15:0] pass_cnt, fail_cnt;
  int total = 0, bad = 0;
  mips_result_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .inst(inst), .rs_value(rs_value),
    .rt_value(rt_value), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value), .clr(clr),
    .op_done(op_done), .op_err(op_err), .fault(fault), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .q_full(q_full), .q_empty(q_empty)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] inst, a, b;
    logic [4:0]  rd;
    logic [31:0] v;
    logic        ok;
  } vec_t;
  typedef struct {
    logic        ok;
    logic [4:0]  d;
    logic [31:0] v;
  } exp_t;
  vec_t tv [12];
  exp_t mq [$];
  function automatic logic [31:0] rty(int rs, int rt, int rd, logic [5:0] f);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction
  function automatic logic [31:0] ity(logic [5:0] op, int rs, int rt, logic [15:0] im);
    return {op, 5'(rs), 5'(rt), im};
  endfunction
  function automatic exp_t model(logic [31:0] i, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e.ok = 1;
    e.v = 0;
    e.d = i[31:26] == 0 ? i[15:11] : i[20:16];
    if (i[31:26] == 6'h00)
      case (i[5:0])
        6'h20: e.v = a + b;
        6'h22: e.v = a - b;
        6'h24: e.v = a & b;
        6'h25: e.v = a | b;
        6'h27: e.v = ~(a | b);
        6'h26: e.v = a ^ b;
        6'h2A: e.v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: e.ok = 0;
      endcase
    else if (i[31:26] == 6'h08) e.v = a + {{16{i[15]}}, i[15:0]};
    else e.ok = 0;
    if (e.d == 0) e.ok = 0;
    return e;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(logic [31:0] i, logic [31:0] a, logic [31:0] b);
    inst = i; rs_value = a; rt_value = b; issue_valid = 1;
    step();
    issue_valid = 0;
  endtask
  task automatic wb(logic [4:0] rd, logic [31:0] v);
    wb_rd = rd; wb_value = v; wb_valid = 1;
    step();
    wb_valid = 0;
  endtask
  task automatic do_clr();
    clr = 1;
    step();
    clr = 0;
  endtask
  initial begin
    int ep, ef, hw, wbp;
    logic do_wb, do_iss, e_done, e_err;
    exp_t e, h;
    logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2A};
    rst_n = 0; issue_valid = 0; wb_valid = 0; clr = 0;
    inst = 0; rs_value = 0; rt_value = 0; wb_rd = 0; wb_value = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q_empty", q_empty, 1); chk("rst_q_full", q_full, 0); chk("rst_fault", fault, 0);
    chk("rst_pass", pass_cnt, 0); chk("rst_fail", fail_cnt, 0);
    chk("rst_done", op_done, 0); chk("rst_err", op_err, 0);
    rst_n = 1;
    step();
    tv[0]  = '{rty(1, 2, 3, 6'h20), 5, 7, 3, 12, 1};
    tv[1]  = '{ity(6'h08, 1, 4, 16'hFFFF), 1, 0, 4, 1, 0};
    tv[2]  = '{rty(1, 2, 5, 6'h2A), 32'hFFFFFFFF, 1, 5, 1, 1};
    tv[3]  = '{rty(1, 2, 6, 6'h27), 0, 0, 6, 32'hFFFFFFFF, 1};
    tv[4]  = '{rty(1, 2, 7, 6'h22), 3, 5, 7, 32'hFFFFFFFE, 1};
    tv[5]  = '{rty(1, 2, 8, 6'h24), 32'hF0F0, 32'hFF00, 8, 32'hF000, 1};
    tv[6]  = '{rty(1, 2, 9, 6'h25), 32'hF0F0, 32'h0F0F, 9, 32'hFFFF, 1};
    tv[7]  = '{rty(1, 2, 10, 6'h26), 32'hFF, 32'h0F, 10, 32'hF0, 1};
    tv[8]  = '{rty(1, 2, 11, 6'h20), 1, 1, 12, 2, 0};
    tv[9]  = '{ity(6'h08, 1, 2, 16'h8000), 32'h10000, 0, 2, 32'h8000, 1};
    tv[10] = '{rty(1, 2, 13, 6'h2A), 1, 32'hFFFFFFFF, 13, 0, 1};
    tv[11] = '{rty(1, 2, 14, 6'h20), 32'hFFFFFFFF, 1, 14, 0, 1};
    ep = 0; ef = 0;
    for (int i = 0; i < 12; i++) begin
      issue(tv[i].inst, tv[i].a, tv[i].b);
      step();
      wb(tv[i].rd, tv[i].v);
      if (tv[i].ok) ep++; else ef++;
      chk($sformatf("tbl%0d_done", i), op_done, tv[i].ok);
      chk($sformatf("tbl%0d_err", i), op_err, !tv[i].ok);
      chk($sformatf("tbl%0d_pass", i), pass_cnt, ep);
      chk($sformatf("tbl%0d_fail", i), fail_cnt, ef);
      chk($sformatf("tbl%0d_empty", i), q_empty, 1);
    end
    issue(rty(1, 2, 5, 6'h2A), 32'hFFFFFFFF, 1);
    issue(rty(1, 2, 6, 6'h27), 0, 0);
    chk("pair_not_empty", q_empty, 0);
    wb(5, 1);
    chk("pair_slt_done", op_done, 1);
    wb(6, 32'hFFFFFFFF);
    chk("pair_nor_done", op_done, 1);
    ep += 2;
    chk("pair_pass", pass_cnt, ep);
    step();
    chk("pulse_width", op_done, 0);
    issue(rty(1, 2, 3, 6'h20), 1, 2);
    for (int k = 0; k < TIMEOUT; k++) begin
      step();
      chk("to_early", op_err, 0);
    end
    step();
    ef++;
    chk("to_err", op_err, 1); chk("to_empty", q_empty, 1); chk("to_fail", fail_cnt, ef); chk("to_fault", fault, 0);
    step();
    chk("to_pulse", op_err, 0);
    issue(ity(6'h23, 1, 5, 16'h4), 1, 1);
    issue(ity(6'h2B, 1, 5, 16'h4), 1, 1);
    issue(ity(6'h04, 1, 5, 16'h4), 1, 1);
    issue({6'h02, 26'h123}, 1, 1);
    issue(rty(1, 2, 0, 6'h20), 1, 1);
    issue(ity(6'h08, 1, 0, 16'h1), 1, 1);
    issue(rty(1, 2, 3, 6'h21), 1, 1);
    chk("untracked_empty", q_empty, 1);
    chk("untracked_fault", fault, 0);
    wb(1, 0);
    chk("under_fault", fault, 1);
    chk("under_fail_frozen", fail_cnt, ef);
    issue(rty(1, 2, 3, 6'h20), 1, 1);
    chk("fault_ignores_issue", q_empty, 1);
    do_clr();
    chk("clr1_fault", fault, 0); chk("clr1_pass", pass_cnt, 0); chk("clr1_fail", fail_cnt, 0);
    for (int i = 0; i < DEPTH; i++) issue(rty(1, 2, i + 1, 6'h20), i, 1);
    chk("ovf_full", q_full, 1); chk("ovf_nofault", fault, 0);
    issue(rty(1, 2, 9, 6'h20), 1, 1);
    chk("ovf_fault", fault, 1); chk("ovf_frozen_full", q_full, 1);
    do_clr();
    chk("clr2_fault", fault, 0); chk("clr2_empty", q_empty, 1); chk("clr2_full", q_full, 0);
    chk("clr2_pass", pass_cnt, 0); chk("clr2_fail", fail_cnt, 0);
    issue(rty(1, 2, 3, 6'h20), 2, 3);
    wb(3, 5);
    chk("post_clr_done", op_done, 1); chk("post_clr_pass", pass_cnt, 1);
    issue(rty(1, 2, 3, 6'h20), 2, 3);
    chk("arst_pre", q_empty, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_empty", q_empty, 1); chk("arst_pass", pass_cnt, 0); chk("arst_done", op_done, 0);
    rst_n = 1;
    step();
    mq.delete();
    hw = 0; ep = 0; ef = 0;
    for (int c = 0; c < 800; c++) begin
      wbp = (c % 200) < 120 ? 60 : 4;
      do_wb = mq.size() != 0 && $urandom_range(0, 99) < wbp;
      do_iss = !(mq.size() == DEPTH && !do_wb) && $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 9))
        7: inst = ity(6'h08, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
        8: inst = ity(6'h23, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
        9: inst = rty($urandom_range(0, 31), 1, $urandom_range(0, 31), 6'h21);
        default: inst = rty($urandom_range(0, 31), 1, $urandom_range(0, 31), fns[$urandom_range(0, 6)]);
      endcase
      rs_value = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      rt_value = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom;
      issue_valid = do_iss;
      wb_valid = do_wb;
      e_done = 0; e_err = 0;
      if (do_wb) begin
        h = mq.pop_front();
        wb_rd = h.d;
        wb_value = $urandom_range(0, 3) == 0 ? h.v ^ 32'h1 : h.v;
        if (wb_value == h.v) begin e_done = 1; ep++; end else begin e_err = 1; ef++; end
        hw = 0;
      end else if (mq.size() != 0) begin
        if (hw == TIMEOUT) begin
          void'(mq.pop_front());
          e_err = 1; ef++; hw = 0;
        end else hw++;
      end
      e = model(inst, rs_value, rt_value);
      if (do_iss && e.ok) mq.push_back(e);
      if (mq.size() == 0) hw = 0;
      step();
      issue_valid = 0; wb_valid = 0;
      chk("rnd_done", op_done, e_done); chk("rnd_err", op_err, e_err);
      chk("rnd_pass", pass_cnt, ep); chk("rnd_fail", fail_cnt, ef);
      chk("rnd_empty", q_empty, mq.size() == 0); chk("rnd_full", q_full, mq.size() == DEPTH);
      chk("rnd_fault", fault, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
